fpnew_sdotp_result_buffer: RTL
==============================

Name: fpnew_sdotp_result_buffer

Overview:
Output-side elastic buffer placed directly downstream of the SDOTP multi-format lane wrapper. It captures each result beat (result, status, extension bit, tag, mask, aux) into a small FIFO. It decouples the dotp pipeline from a consumer that may stall. It also keeps a sticky accumulation of the fflags of all unmasked results that have been handed out.

Parameters:
LaneWidth, 64, width of result data in bits
Depth, 4, FIFO entries; must be a power of two and at least 2
TagType, logic, tag type carried alongside each result
AuxType, logic, aux type carried alongside each result

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
flush_i  in  1  synchronous discard of all buffered entries
in_result_i  in  LaneWidth  result from the sdotp wrapper
in_status_i  in  5  fpnew_pkg::status_t {NV,DZ,OF,UF,NX}
in_extension_bit_i  in  1  extension bit from the wrapper
in_tag_i  in  TagType  tag
in_mask_i  in  1  lane mask; 0 means the result is not architecturally visible
in_aux_i  in  AuxType  aux
in_valid_i  in  1  upstream valid
in_ready_o  out  1  upstream ready; drives the wrapper's out_ready_i
out_result_o  out  LaneWidth  head result
out_status_o  out  5  head status
out_extension_bit_o  out  1  head extension bit
out_tag_o  out  TagType  head tag
out_mask_o  out  1  head mask
out_aux_o  out  AuxType  head aux
out_valid_o  out  1  head valid
out_ready_i  in  1  consumer ready
clear_status_i  in  1  clear the sticky flags
status_acc_o  out  5  sticky OR of popped unmasked status
count_o  out  $clog2(Depth)+1  occupancy
busy_o  out  1  count_o != 0 or the upstream wrapper is busy (see below)
up_busy_i  in  1  busy_o from the sdotp wrapper

Behaviour:
- Reset (rst_ni low, asynchronous): read pointer, write pointer and count go to 0. status_acc_o = 0, out_valid_o = 0, in_ready_o = 1 after release. Data outputs = 0.
- Push = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i.
- in_ready_o = (count_o != Depth) | out_ready_i.
  - Full with a simultaneous pop accepts the push.
  - in_ready_o must not depend combinationally on in_valid_i.
- out_valid_o = (count_o != 0). Head data is read from the RAM at the read pointer.
- Latency: 1 cycle from push to out_valid_o when empty (no fall-through by default).
- Pointers are log2(Depth) bits and wrap modulo Depth. count_o is updated by +1 on push only, -1 on pop only, unchanged on both.
- Simultaneous push and pop when count_o == 1: the head pops, the new entry becomes head next cycle, and out_valid_o stays 1.
- Push while empty and pop are mutually exclusive by construction, since out_valid_o = 0.
- Payload must hold while out_valid_o & !out_ready_i. An entry is written only on push.
- Sticky flags:
  - on pop with out_mask_o = 1: status_acc_o <= status_acc_o | out_status_o
  - on pop with out_mask_o = 0: no change
  - clear_status_i alone: status_acc_o <= 0
  - clear_status_i together with an unmasked pop: status_acc_o <= out_status_o. The popped flags are not lost.
- flush_i:
  - next cycle: pointers and count = 0, out_valid_o = 0
  - a push in the same cycle is discarded
  - a pop in the same cycle still completes its handshake and updates status_acc_o
  - status_acc_o is otherwise untouched by flush
- busy_o = (count_o != 0) | up_busy_i.
- Overflow and underflow are impossible under the handshake rules. An assertion checks count_o <= Depth.

Optional Feature:
FPNEW_SDOTP_RESBUF_FALLTHROUGH_EN
- Defined: when count_o == 0 and in_valid_i = 1, the input beat is forwarded combinationally to the out_* ports with out_valid_o = 1.
  - If out_ready_i = 1 in that cycle, the beat is consumed without being written (count stays 0) and status accumulates as for a pop.
  - Otherwise the beat is stored as usual.
  - Push-to-output latency is 0.
- Undefined: no bypass path; latency is 1 cycle as above.

Test Plan:
- Reset then single push (result=0x3F80_0000_0000_0000, status=5'b00001, mask=1) with out_ready_i=1 -> out_valid_o rises next cycle with the same data; after the pop, status_acc_o=5'b00001 and count_o=0.
- out_ready_i=0, push 5 beats with Depth=4 -> 4 accepted, in_ready_o=0 on the 5th. Raise out_ready_i -> the 5th is accepted in the same cycle as pop #1, and beats drain in order 1..5.
- Pop beat status=5'b10000 mask=0, then beat status=5'b00100 mask=1 -> status_acc_o=5'b00100.
- status_acc_o=5'b00001; clear_status_i together with an unmasked pop of status=5'b01000 -> status_acc_o=5'b01000.
- Buffer holds 3 entries; flush_i together with a push -> count_o=0 and out_valid_o=0 next cycle; the pushed beat never appears.
- Assert rst_ni low mid-stream with 2 entries -> outputs clear immediately without waiting for a clock edge. After release, in_ready_o=1 and status_acc_o=0.

Source files
------------

// File: rtl/fpnew_sdotp_result_buffer.sv
// Elastic output buffer behind the SDOTP lane wrapper, with sticky fflags of handed-out unmasked results.
// Optional combinational bypass when empty: FPNEW_SDOTP_RESBUF_FALLTHROUGH_EN.
module fpnew_sdotp_result_buffer #(
  parameter int unsigned LaneWidth = 64,
  parameter int unsigned Depth     = 4,
  parameter type         TagType   = logic,
  parameter type         AuxType   = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [LaneWidth-1:0]       in_result_i,
  input  logic [4:0]                 in_status_i,
  input  logic                       in_extension_bit_i,
  input  TagType                     in_tag_i,
  input  logic                       in_mask_i,
  input  AuxType                     in_aux_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [LaneWidth-1:0]       out_result_o,
  output logic [4:0]                 out_status_o,
  output logic                       out_extension_bit_o,
  output TagType                     out_tag_o,
  output logic                       out_mask_o,
  output AuxType                     out_aux_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  input  logic                       clear_status_i,
  output logic [4:0]                 status_acc_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       busy_o,
  input  logic                       up_busy_i
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  typedef struct packed {
    logic [LaneWidth-1:0] result;
    logic [4:0]           status;
    logic                 ext;
    TagType               tag;
    logic                 mask;
    AuxType               aux;
  } entry_t;

  entry_t           mem_q [Depth];
  entry_t           in_entry;
  entry_t           head;
  logic [AddrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [4:0]       status_acc_q;
  logic             empty, full, bypass;
  logic             push, pop, store, consume;

  always_comb begin
    in_entry        = '0;
    in_entry.result = in_result_i;
    in_entry.status = in_status_i;
    in_entry.ext    = in_extension_bit_i;
    in_entry.tag    = in_tag_i;
    in_entry.mask   = in_mask_i;
    in_entry.aux    = in_aux_i;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(Depth));

`ifdef FPNEW_SDOTP_RESBUF_FALLTHROUGH_EN
  assign bypass = empty & in_valid_i;
`else
  assign bypass = 1'b0;
`endif

  // Ready looks only at occupancy and the consumer, never at in_valid_i.
  assign in_ready_o  = ~full | out_ready_i;
  assign out_valid_o = ~empty | bypass;
  assign head        = bypass ? in_entry : mem_q[rd_ptr_q];

  assign push    = in_valid_i & in_ready_o;
  assign pop     = out_valid_o & out_ready_i;
  // A bypassed beat that is taken immediately never occupies a slot.
  assign store   = push & ~(bypass & out_ready_i) & ~flush_i;
  assign consume = pop & ~bypass;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (store) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (store)   wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (consume) rd_ptr_q <= rd_ptr_q + AddrW'(1);
      case ({store, consume})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A clear coinciding with an unmasked pop keeps the popped flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_acc_q <= '0;
    end else if (pop && head.mask) begin
      status_acc_q <= clear_status_i ? head.status : (status_acc_q | head.status);
    end else if (clear_status_i) begin
      status_acc_q <= '0;
    end
  end

  assign out_result_o        = head.result;
  assign out_status_o        = head.status;
  assign out_extension_bit_o = head.ext;
  assign out_tag_o           = head.tag;
  assign out_mask_o          = head.mask;
  assign out_aux_o           = head.aux;
  assign status_acc_o        = status_acc_q;
  assign count_o             = count_q;
  assign busy_o              = ~empty | up_busy_i;

`ifndef SYNTHESIS
  count_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= CntW'(Depth));
`endif

endmodule
